// File: rtl/calc_pkg.sv
// Shared key codes, opcodes and sequencer state encoding for the calculator
// key path.
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_DIV = 4'hD;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      OP_WAIT = 2'd1,
      ENTER_B = 2'd2,
      ISSUE   = 2'd3
   } seq_state_t;

   function automatic logic is_operator(input logic [3:0] code);
      return (code >= KEY_ADD) && (code <= KEY_DIV);
   endfunction

   function automatic logic [1:0] key_to_opcode(input logic [3:0] code);
      logic [1:0] op;
      case (code)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         KEY_DIV: op = OP_DIV;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns the scanner's level-valid key stream into one event per physical press;
// press and release must each hold STABLE_CYCLES samples to be recognised.
module key_debounce #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       keytype,
   input  logic       valid_iteration,
   output logic       event_pulse,
   output logic [3:0] event_key,
   output logic       event_keytype
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [3:0] key_q;
   logic       type_q;
   logic       valid_q;
   logic [3:0] track_key;
   logic       track_type;
   logic [7:0] count;
   logic       armed;

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_q      <= 4'd0;
         type_q     <= 1'b0;
         valid_q    <= 1'b0;
         track_key  <= 4'd0;
         track_type <= 1'b0;
         count      <= 8'd0;
         armed      <= 1'b1;
      end else begin
         key_q   <= key;
         type_q  <= keytype;
         valid_q <= valid_iteration;
         if (armed) begin
            if (count == STABLE) begin
               armed <= 1'b0;
               count <= 8'd0;
            end else if (!valid_q) begin
               count <= 8'd0;
            end else if ((count != 8'd0) && (key_q == track_key) && (type_q == track_type)) begin
               count <= count + 8'd1;
            end else begin
               // First sample of a new (or changed) key starts a fresh run.
               count      <= 8'd1;
               track_key  <= key_q;
               track_type <= type_q;
            end
         end else begin
            if (valid_q) begin
               count <= 8'd0;
            end else if (count + 8'd1 == STABLE) begin
               armed <= 1'b1;
               count <= 8'd0;
            end else begin
               count <= count + 8'd1;
            end
         end
      end
   end

   assign event_pulse   = armed && (count == STABLE);
   assign event_key     = track_key;
   assign event_keytype = track_type;

endmodule

// File: rtl/calc_key_sequencer.sv
// Assembles debounced key events into "A op B" and hands the expression to the
// arithmetic unit. Define CALC_CLEAR_ENTRY_EN to make F in ENTER_B clear only B.
module calc_key_sequencer
   import calc_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          key,
   input  logic                keytype,
   input  logic                valid_iteration,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] operand_a,
   output logic [4*DIGITS-1:0] operand_b,
   output logic [1:0]          opcode,
   output logic [4*DIGITS-1:0] display_bcd,
   output logic                entry_overflow
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);

   logic       ev;
   logic [3:0] ev_key;
   logic       ev_keytype;

   key_debounce #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_debounce (
      .clock          (clock),
      .reset          (reset),
      .key            (key),
      .keytype        (keytype),
      .valid_iteration(valid_iteration),
      .event_pulse    (ev),
      .event_key      (ev_key),
      .event_keytype  (ev_keytype)
   );

   seq_state_t    state, state_n;
   logic [W-1:0]  op_a_n, op_b_n;
   logic [1:0]    opcode_n;
   logic [CW-1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
   logic          out_valid_n;
   logic          ovf_n;
   logic          full_clear;

   logic is_digit, is_oper, is_eq, is_clr;
   logic [W-1:0] digit_w;

   assign is_digit = ev && ev_keytype && (ev_key <= 4'd9);
   assign is_oper  = ev && !ev_keytype && is_operator(ev_key);
   assign is_eq    = ev && !ev_keytype && (ev_key == KEY_EQ);
   assign is_clr   = ev && !ev_keytype && (ev_key == KEY_CLR);
   assign digit_w  = {{(W-4){1'b0}}, ev_key};

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n     = state;
      op_a_n      = operand_a;
      op_b_n      = operand_b;
      opcode_n    = opcode;
      cnt_a_n     = cnt_a;
      cnt_b_n     = cnt_b;
      out_valid_n = out_valid;
      ovf_n       = 1'b0;
      full_clear  = 1'b0;

      case (state)
         ENTER_A: begin
            if (is_digit) begin
               if (cnt_a < FULL) begin
                  op_a_n  = (operand_a << 4) | digit_w;
                  cnt_a_n = cnt_a + CW'(1);
               end else begin
                  ovf_n = 1'b1;
               end
            end else if (is_oper) begin
               opcode_n = key_to_opcode(ev_key);
               state_n  = OP_WAIT;
            end else if (is_clr) begin
               full_clear = 1'b1;
            end
         end
         OP_WAIT: begin
            if (is_digit) begin
               op_b_n  = digit_w;
               cnt_b_n = CW'(1);
               state_n = ENTER_B;
            end else if (is_oper) begin
               opcode_n = key_to_opcode(ev_key);
            end else if (is_clr) begin
               full_clear = 1'b1;
            end
         end
         ENTER_B: begin
            if (is_digit) begin
               if (cnt_b < FULL) begin
                  op_b_n  = (operand_b << 4) | digit_w;
                  cnt_b_n = cnt_b + CW'(1);
               end else begin
                  ovf_n = 1'b1;
               end
            end else if (is_eq) begin
               out_valid_n = 1'b1;
               state_n     = ISSUE;
            end else if (is_clr) begin
`ifdef CALC_CLEAR_ENTRY_EN
               op_b_n  = '0;
               cnt_b_n = '0;
               state_n = OP_WAIT;
`else
               full_clear = 1'b1;
`endif
            end
         end
         ISSUE: begin
            // Expression stays frozen and key events are dropped until taken.
            if (out_valid && out_ready) begin
               out_valid_n = 1'b0;
               full_clear  = 1'b1;
            end
         end
         default: state_n = ENTER_A;
      endcase

      if (full_clear) begin
         op_a_n   = '0;
         op_b_n   = '0;
         opcode_n = OP_ADD;
         cnt_a_n  = '0;
         cnt_b_n  = '0;
         state_n  = ENTER_A;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= ENTER_A;
         operand_a      <= '0;
         operand_b      <= '0;
         opcode         <= OP_ADD;
         cnt_a          <= '0;
         cnt_b          <= '0;
         out_valid      <= 1'b0;
         entry_overflow <= 1'b0;
      end else begin
         state          <= state_n;
         operand_a      <= op_a_n;
         operand_b      <= op_b_n;
         opcode         <= opcode_n;
         cnt_a          <= cnt_a_n;
         cnt_b          <= cnt_b_n;
         out_valid      <= out_valid_n;
         entry_overflow <= ovf_n;
      end
   end

   assign display_bcd = ((state == ENTER_A) || (state == OP_WAIT)) ? operand_a : operand_b;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: key entry, debounce, overflow,
// back-pressure, clear and asynchronous reset.
module tb_calc_key_sequencer;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic         clock;
   logic         reset;
   logic [3:0]   key;
   logic         keytype;
   logic         valid_iteration;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic [1:0]   opcode;
   logic [W-1:0] display_bcd;
   logic         entry_overflow;

   int checks = 0;
   int errors = 0;

   int           xfer_count = 0;
   int           ovf_count  = 0;
   logic [W-1:0] cap_a;
   logic [W-1:0] cap_b;
   logic [1:0]   cap_op;

   calc_key_sequencer #(
      .DIGITS       (DIGITS),
      .STABLE_CYCLES(4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .key            (key),
      .keytype        (keytype),
      .valid_iteration(valid_iteration),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .opcode         (opcode),
      .display_bcd    (display_bcd),
      .entry_overflow (entry_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record each handshake and overflow pulse seen at a clock edge.
   always @(posedge clock) begin
      if (out_valid && out_ready) begin
         xfer_count++;
         cap_a  = operand_a;
         cap_b  = operand_b;
         cap_op = opcode;
      end
      if (entry_overflow) ovf_count++;
   end

   task automatic press(input logic [3:0] k, input int hold, input int rel);
      @(negedge clock);
      key             = k;
      keytype         = (k <= 4'd9);
      valid_iteration = 1'b1;
      repeat (hold) @(negedge clock);
      valid_iteration = 1'b0;
      repeat (rel) @(negedge clock);
   endtask

   task automatic tap(input logic [3:0] k);
      press(k, 10, 10);
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      key             = 4'd0;
      keytype         = 1'b0;
      valid_iteration = 1'b0;
      out_ready       = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if ({operand_a, operand_b, opcode} !== '0) begin
         errors++; $display("FAIL reset_operands: got a=%h b=%h op=%b expected all 0", operand_a, operand_b, opcode);
      end
      checks++;
      if ({display_bcd, entry_overflow} !== '0) begin
         errors++; $display("FAIL reset_display: got disp=%h ovf=%b expected 0", display_bcd, entry_overflow);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int x0;
      x0 = xfer_count;
      out_ready = 1'b1;
      tap(4'd1); tap(4'd2); tap(4'hA); tap(4'd3); tap(4'hE);
      checks++;
      if (xfer_count - x0 !== 1) begin
         errors++; $display("FAIL basic_xfers: got %0d expected 1", xfer_count - x0);
      end
      checks++;
      if ({cap_a, cap_b, cap_op} !== {16'h0012, 16'h0003, 2'b00}) begin
         errors++; $display("FAIL basic_expr: got a=%h b=%h op=%b expected a=0012 b=0003 op=00", cap_a, cap_b, cap_op);
      end
      checks++;
      if ({out_valid, operand_a, operand_b, opcode, display_bcd} !== '0) begin
         errors++; $display("FAIL basic_cleared: got v=%b a=%h b=%h op=%b disp=%h expected all 0",
                            out_valid, operand_a, operand_b, opcode, display_bcd);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_debounce();
      @(negedge clock);
      key = 4'd5; keytype = 1'b1; valid_iteration = 1'b1;
      repeat (2) @(negedge clock);
      valid_iteration = 1'b0;
      repeat (10) @(negedge clock);
      checks++;
      if (display_bcd !== 16'h0000) begin
         errors++; $display("FAIL glitch_ignored: got disp=%h expected 0000", display_bcd);
      end
      press(4'd7, 50, 10);
      checks++;
      if (display_bcd !== 16'h0007) begin
         errors++; $display("FAIL long_hold_single: got disp=%h expected 0007", display_bcd);
      end
      tap(4'hF);
      checks++;
      if (display_bcd !== 16'h0000) begin
         errors++; $display("FAIL clear_after_hold: got disp=%h expected 0000", display_bcd);
      end
   endtask

   task automatic test_overflow();
      int o0;
      o0 = ovf_count;
      tap(4'd9); tap(4'd8); tap(4'd7); tap(4'd6);
      checks++;
      if (ovf_count - o0 !== 0) begin
         errors++; $display("FAIL ovf_early: got %0d pulses expected 0", ovf_count - o0);
      end
      tap(4'd5);
      checks++;
      if (ovf_count - o0 !== 1) begin
         errors++; $display("FAIL ovf_fifth: got %0d pulses expected 1", ovf_count - o0);
      end
      checks++;
      if ({operand_a, display_bcd} !== {16'h9876, 16'h9876}) begin
         errors++; $display("FAIL ovf_operand: got a=%h disp=%h expected 9876", operand_a, display_bcd);
      end
      tap(4'hF);
   endtask

   task automatic test_zero_operand();
      int x0;
      x0 = xfer_count;
      out_ready = 1'b1;
      tap(4'hB); tap(4'd5); tap(4'hE);
      checks++;
      if (xfer_count - x0 !== 1) begin
         errors++; $display("FAIL zero_a_xfers: got %0d expected 1", xfer_count - x0);
      end
      checks++;
      if ({cap_a, cap_b, cap_op} !== {16'h0000, 16'h0005, 2'b01}) begin
         errors++; $display("FAIL zero_a_expr: got a=%h b=%h op=%b expected a=0000 b=0005 op=01", cap_a, cap_b, cap_op);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      int x0;
      x0 = xfer_count;
      out_ready = 1'b0;
      tap(4'd4); tap(4'hC); tap(4'hD); tap(4'd2); tap(4'hE);
      checks++;
      if ({out_valid, opcode, operand_a, operand_b} !== {1'b1, 2'b11, 16'h0004, 16'h0002}) begin
         errors++; $display("FAIL bp_hold: got v=%b op=%b a=%h b=%h expected v=1 op=11 a=0004 b=0002",
                            out_valid, opcode, operand_a, operand_b);
      end
      checks++;
      if (display_bcd !== 16'h0002) begin
         errors++; $display("FAIL bp_display: got %h expected 0002", display_bcd);
      end
      tap(4'hF);
      checks++;
      if ({out_valid, opcode, operand_a, operand_b} !== {1'b1, 2'b11, 16'h0004, 16'h0002}) begin
         errors++; $display("FAIL bp_clear_ignored: got v=%b op=%b a=%h b=%h expected v=1 op=11 a=0004 b=0002",
                            out_valid, opcode, operand_a, operand_b);
      end
      checks++;
      if (xfer_count - x0 !== 0) begin
         errors++; $display("FAIL bp_no_xfer: got %0d expected 0", xfer_count - x0);
      end
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (xfer_count - x0 !== 1) begin
         errors++; $display("FAIL bp_xfer: got %0d expected 1", xfer_count - x0);
      end
      checks++;
      if ({cap_a, cap_b, cap_op} !== {16'h0004, 16'h0002, 2'b11}) begin
         errors++; $display("FAIL bp_expr: got a=%h b=%h op=%b expected a=0004 b=0002 op=11", cap_a, cap_b, cap_op);
      end
      checks++;
      if ({out_valid, display_bcd} !== '0) begin
         errors++; $display("FAIL bp_after: got v=%b disp=%h expected 0", out_valid, display_bcd);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_clear();
      tap(4'd7); tap(4'hB); tap(4'd3); tap(4'hF);
`ifdef CALC_CLEAR_ENTRY_EN
      checks++;
      if ({operand_a, opcode, operand_b, display_bcd} !== {16'h0007, 2'b01, 16'h0000, 16'h0007}) begin
         errors++; $display("FAIL clear_entry: got a=%h op=%b b=%h disp=%h expected a=0007 op=01 b=0000 disp=0007",
                            operand_a, opcode, operand_b, display_bcd);
      end
      tap(4'hF);
`else
      checks++;
      if ({operand_a, opcode, operand_b, display_bcd} !== '0) begin
         errors++; $display("FAIL clear_full: got a=%h op=%b b=%h disp=%h expected all 0",
                            operand_a, opcode, operand_b, display_bcd);
      end
`endif
      tap(4'd2);
      checks++;
      if (operand_a !== 16'h0002) begin
         errors++; $display("FAIL clear_reentry: got a=%h expected 0002", operand_a);
      end
      tap(4'hF);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      tap(4'd6); tap(4'hA); tap(4'd1); tap(4'hE);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL areset_pre: got v=%b expected 1", out_valid);
      end
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, operand_a, operand_b, opcode, display_bcd} !== '0) begin
         errors++; $display("FAIL areset_immediate: got v=%b a=%h b=%h op=%b disp=%h expected all 0",
                            out_valid, operand_a, operand_b, opcode, display_bcd);
      end
      @(negedge clock);
      reset = 1'b0;
      tap(4'd3);
      checks++;
      if (display_bcd !== 16'h0003) begin
         errors++; $display("FAIL areset_recover: got disp=%h expected 0003", display_bcd);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_debounce();
      test_overflow();
      test_zero_operand();
      test_back_pressure();
      test_clear();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
